// File: rtl/instr_seq_pkg.sv
// Shared types for the 3-bit-opcode core: sequencer states, opcodes and default widths.
// Also used by the control decoder.
package instr_seq_pkg;

    localparam int PC_W_DEF = 10;
    localparam int IW_DEF   = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_e;

    typedef enum logic [2:0] {
        OP_LDR   = 3'b000,
        OP_STR   = 3'b001,
        OP_MOV   = 3'b010,
        OP_XOR   = 3'b011,
        OP_AND   = 3'b100,
        OP_SHIFT = 3'b101,
        OP_CMP   = 3'b110,
        OP_BR    = 3'b111
    } opcode_e;

    // True for opcodes whose write-back stage updates the register file.
    function automatic logic writes_reg(input opcode_e op);
        logic wr;
        case (op)
            OP_LDR, OP_MOV, OP_XOR, OP_AND, OP_SHIFT: wr = 1'b1;
            default:                                  wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: start/ROM/branch/data-memory inputs and the sequencer's strobes.
// master = sequencer side, slave = surrounding core/environment.
interface instr_sequencer_if
    import instr_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int IW   = IW_DEF
);
    logic            start;
    logic [IW-1:0]   instr;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            mem_ack;
    logic [PC_W-1:0] pc;
    logic            ifetch_en;
    logic [IW-1:0]   ir;
    logic            ir_valid;
    logic            mem_req;
    logic            mem_we;
    logic            reg_we;
    logic            flag_we;
    logic            busy;
    logic            done;

    modport master (
        input  start, instr, br_taken, br_target, mem_ack,
        output pc, ifetch_en, ir, ir_valid, mem_req, mem_we, reg_we, flag_we, busy, done
    );

    modport slave (
        output start, instr, br_taken, br_target, mem_ack,
        input  pc, ifetch_en, ir, ir_valid, mem_req, mem_we, reg_we, flag_we, busy, done
    );
endinterface

// File: rtl/seq_perf_counters.sv
// Saturating busy-cycle and retired-instruction counters for instr_sequencer.
// Only instantiated when INSTR_SEQ_PERF_EN is defined.
module seq_perf_counters (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        busy,
    input  logic        retire,
    output logic [31:0] cycle_cnt,
    output logic [15:0] retired_cnt
);
    logic [31:0] cycle_cnt_r;
    logic [15:0] retired_cnt_r;

    // Counters clear on a newly accepted start and hold at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_r   <= 32'd0;
            retired_cnt_r <= 16'd0;
        end else if (clear) begin
            cycle_cnt_r   <= 32'd0;
            retired_cnt_r <= 16'd0;
        end else begin
            if (busy && (cycle_cnt_r != 32'hFFFF_FFFF)) begin
                cycle_cnt_r <= cycle_cnt_r + 32'd1;
            end
            if (retire && (retired_cnt_r != 16'hFFFF)) begin
                retired_cnt_r <= retired_cnt_r + 16'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_r;
    assign retired_cnt = retired_cnt_r;
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns pc and ir, issues per-phase strobes.
// Optional INSTR_SEQ_PERF_EN adds cycle_cnt / retired_cnt counters.
module instr_sequencer
    import instr_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    instr_sequencer_if.master   bus
`ifdef INSTR_SEQ_PERF_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [15:0]         retired_cnt
`endif
);
    localparam int PC_W = PC_W_DEF;
    localparam int IW   = IW_DEF;

    seq_state_e      state_r, state_nx_s;
    logic [PC_W-1:0] pc_r, pc_nx_s, pc_inc_s;
    logic [IW-1:0]   ir_r, ir_nx_s;
    opcode_e         op_s, op_nx_s;

    logic ifetch_en_r, ir_valid_r, mem_req_r, mem_we_r, reg_we_r, flag_we_r, busy_r, done_r;
    logic ifetch_en_nx_s, ir_valid_nx_s, mem_req_nx_s, mem_we_nx_s;
    logic reg_we_nx_s, flag_we_nx_s, busy_nx_s, done_nx_s;

    assign op_s     = opcode_e'(ir_r[IW-1 -: 3]);
    assign op_nx_s  = opcode_e'(ir_nx_s[IW-1 -: 3]);
    assign pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};

    // Next-state, next-pc and instruction latch selection.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        ir_nx_s    = ir_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nx_s = ST_FETCH;
                    pc_nx_s    = {PC_W{1'b0}};
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_FETCH:  state_nx_s = ST_DECODE;
            ST_DECODE: begin
                ir_nx_s    = bus.instr;
                state_nx_s = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_s)
                    OP_LDR, OP_STR: state_nx_s = ST_MEM;
                    OP_BR: begin
                        if (!bus.br_taken) begin
                            pc_nx_s    = pc_inc_s;
                            state_nx_s = ST_FETCH;
                        end else if (bus.br_target != pc_r) begin
                            pc_nx_s    = bus.br_target;
                            state_nx_s = ST_FETCH;
                        end else begin
                            // Taken branch-to-self is the halt convention.
                            state_nx_s = ST_DONE;
                        end
                    end
                    default: state_nx_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (!bus.mem_ack) begin
                    state_nx_s = ST_MEM;
                end else if (op_s == OP_STR) begin
                    pc_nx_s    = pc_inc_s;
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_WB;
                end
            end
            ST_WB: begin
                pc_nx_s    = pc_inc_s;
                state_nx_s = ST_FETCH;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        ifetch_en_nx_s = (state_nx_s == ST_FETCH);
        ir_valid_nx_s  = (state_nx_s == ST_EXEC) || (state_nx_s == ST_MEM) || (state_nx_s == ST_WB);
        mem_req_nx_s   = (state_nx_s == ST_MEM);
        mem_we_nx_s    = (state_nx_s == ST_MEM) && (op_nx_s == OP_STR);
        reg_we_nx_s    = (state_nx_s == ST_WB) && writes_reg(op_nx_s);
        flag_we_nx_s   = (state_nx_s == ST_WB) && (op_nx_s == OP_CMP);
        busy_nx_s      = (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
        done_nx_s      = (state_nx_s == ST_DONE);
    end

    // Architectural state: sequencer state, program counter, instruction register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            pc_r    <= {PC_W{1'b0}};
            ir_r    <= {IW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
            ir_r    <= ir_nx_s;
        end
    end

    // Output strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ifetch_en_r <= 1'b0;
            ir_valid_r  <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            reg_we_r    <= 1'b0;
            flag_we_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            ifetch_en_r <= ifetch_en_nx_s;
            ir_valid_r  <= ir_valid_nx_s;
            mem_req_r   <= mem_req_nx_s;
            mem_we_r    <= mem_we_nx_s;
            reg_we_r    <= reg_we_nx_s;
            flag_we_r   <= flag_we_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
        end
    end

    assign bus.pc        = pc_r;
    assign bus.ir        = ir_r;
    assign bus.ifetch_en = ifetch_en_r;
    assign bus.ir_valid  = ir_valid_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.reg_we    = reg_we_r;
    assign bus.flag_we   = flag_we_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

`ifdef INSTR_SEQ_PERF_EN
    logic retire_s, clear_s;

    // An instruction retires on WB exit, STR MEM exit and BR EXEC exit (halt included).
    assign retire_s = (state_r == ST_WB)
                   || ((state_r == ST_EXEC) && (op_s == OP_BR))
                   || ((state_r == ST_MEM) && bus.mem_ack && (op_s == OP_STR));
    assign clear_s  = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && bus.start;

    seq_perf_counters u_perf (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear_s),
        .busy        (busy_r),
        .retire      (retire_s),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
    );
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs, expected strobe events queued
// by the stimulus and consumed by a negedge monitor.
module tb_instr_sequencer;
    import instr_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   tcyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   base;

    instr_sequencer_if bus_if ();

`ifdef INSTR_SEQ_PERF_EN
    logic [31:0] cycle_cnt;
    logic [15:0] retired_cnt;
`endif

    instr_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
`ifdef INSTR_SEQ_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    logic [8:0] rom [0:1023];
    logic       tk  [0:1023];
    logic [9:0] tg  [0:1023];
    int         lat [0:1023];

    assign bus_if.instr     = rom[bus_if.pc];
    assign bus_if.br_taken  = tk[bus_if.pc];
    assign bus_if.br_target = tg[bus_if.pc];

    // flags = {ifetch_en, ir_valid, mem_req, mem_we, reg_we, flag_we}
    localparam logic [5:0] EV_F  = 6'b100000;
    localparam logic [5:0] EV_ML = 6'b011000;
    localparam logic [5:0] EV_MS = 6'b011100;
    localparam logic [5:0] EV_R  = 6'b010010;
    localparam logic [5:0] EV_C  = 6'b010001;

    typedef struct {
        int         cyc;
        logic [5:0] flags;
        logic [9:0] pc;
        logic [2:0] op;
    } ev_t;

    ev_t exp_q[$];

    function automatic void exp_ev(int off, logic [5:0] fl, logic [9:0] p, logic [2:0] o);
        ev_t e;
        e.cyc = base + off; e.flags = fl; e.pc = p; e.op = o;
        exp_q.push_back(e);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic wait_cyc(int t);
        while (tcyc < t) @(negedge clk);
    endtask

    task automatic wait_done(int max);
        for (int i = 0; i < max && !bus_if.done; i++) @(negedge clk);
        chk("done_reached", {31'd0, bus_if.done}, 32'd1);
    endtask

    // Data-memory responder: acks after lat[pc] MEM cycles, spurious acks when idle.
    int ack_cnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            ack_cnt = 0;
            bus_if.mem_ack = 1'b0;
        end else if (bus_if.mem_req) begin
            ack_cnt = ack_cnt + 1;
            bus_if.mem_ack = (ack_cnt >= lat[bus_if.pc]);
        end else begin
            ack_cnt = 0;
            bus_if.mem_ack = ((tcyc % 5) == 2);
        end
    end

    // Monitor: every cycle with a strobe must match the head of the expected queue.
    always @(negedge clk) begin
        logic [5:0] fl;
        ev_t e;
        if (reset_n && (bus_if.ifetch_en || bus_if.mem_req || bus_if.reg_we || bus_if.flag_we)) begin
            fl = {bus_if.ifetch_en, bus_if.ir_valid, bus_if.mem_req, bus_if.mem_we,
                  bus_if.reg_we, bus_if.flag_we};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d flags=%b pc=%h", tcyc, fl, bus_if.pc);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != tcyc) || (e.flags != fl) || (e.pc != bus_if.pc) ||
                    (fl[4] && (bus_if.ir[8:6] != e.op))) begin
                    errors++;
                    $display("FAIL strobe_event actual cyc=%0d flags=%b pc=%h op=%b expected cyc=%0d flags=%b pc=%h op=%b",
                             tcyc, fl, bus_if.pc, bus_if.ir[8:6], e.cyc, e.flags, e.pc, e.op);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom[i] = {3'b010, 6'h00};
            tk[i]  = 1'b0;
            tg[i]  = 10'h000;
            lat[i] = 1;
        end
        reset_n = 1'b0;
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_pc", {22'd0, bus_if.pc}, 32'd0);
        chk("rst_ir", {23'd0, bus_if.ir}, 32'd0);
        chk("rst_strobes", {24'd0, bus_if.ifetch_en, bus_if.ir_valid, bus_if.mem_req, bus_if.mem_we,
                            bus_if.reg_we, bus_if.flag_we, bus_if.busy, bus_if.done}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {30'd0, bus_if.busy, bus_if.ifetch_en}, 32'd0);

        // Program A: XOR, BR->5, LDR(lat 3), STR(lat 1), CMP, BR->0x020, BR not taken,
        // BR->0x3FF, MOV wrapping to 0, then halt at 0.
        rom[10'h000] = {3'b011, 6'h15};
        rom[10'h001] = {3'b111, 6'h01}; tk[10'h001] = 1'b1; tg[10'h001] = 10'h005;
        rom[10'h005] = {3'b000, 6'h22}; lat[10'h005] = 3;
        rom[10'h006] = {3'b001, 6'h0A}; lat[10'h006] = 1;
        rom[10'h007] = {3'b110, 6'h33};
        rom[10'h008] = {3'b111, 6'h00}; tk[10'h008] = 1'b1; tg[10'h008] = 10'h020;
        rom[10'h020] = {3'b111, 6'h00}; tk[10'h020] = 1'b0; tg[10'h020] = 10'h100;
        rom[10'h021] = {3'b111, 6'h00}; tk[10'h021] = 1'b1; tg[10'h021] = 10'h3FF;
        rom[10'h3FF] = {3'b010, 6'h11};

        base = tcyc;
        exp_ev( 1, EV_F,  10'h000, 3'b000);
        exp_ev( 4, EV_R,  10'h000, 3'b011);
        exp_ev( 5, EV_F,  10'h001, 3'b000);
        exp_ev( 8, EV_F,  10'h005, 3'b000);
        exp_ev(11, EV_ML, 10'h005, 3'b000);
        exp_ev(12, EV_ML, 10'h005, 3'b000);
        exp_ev(13, EV_ML, 10'h005, 3'b000);
        exp_ev(14, EV_R,  10'h005, 3'b000);
        exp_ev(15, EV_F,  10'h006, 3'b000);
        exp_ev(18, EV_MS, 10'h006, 3'b001);
        exp_ev(19, EV_F,  10'h007, 3'b000);
        exp_ev(22, EV_C,  10'h007, 3'b110);
        exp_ev(23, EV_F,  10'h008, 3'b000);
        exp_ev(26, EV_F,  10'h020, 3'b000);
        exp_ev(29, EV_F,  10'h021, 3'b000);
        exp_ev(32, EV_F,  10'h3FF, 3'b000);
        exp_ev(35, EV_R,  10'h3FF, 3'b010);
        exp_ev(36, EV_F,  10'h000, 3'b000);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;

        wait_cyc(base + 3);
        rom[10'h000] = {3'b111, 6'h00}; tk[10'h000] = 1'b1; tg[10'h000] = 10'h000;
        wait_cyc(base + 10);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("busy_during_run", {31'd0, bus_if.busy}, 32'd1);

        wait_done(100);
        chk("halt_cycle", tcyc - base, 32'd39);
        chk("halt_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("halt_pc", {22'd0, bus_if.pc}, 32'd0);
        chk("halt_ir_valid", {31'd0, bus_if.ir_valid}, 32'd0);
`ifdef INSTR_SEQ_PERF_EN
        chk("perf_cycles_a", cycle_cnt, 32'd38);
        chk("perf_retired_a", {16'd0, retired_cnt}, 32'd10);
`endif
        chk("queue_empty_a", exp_q.size(), 32'd0);

        // Start honoured in DONE: restarts at pc 0, which now holds the halt branch.
        repeat (2) @(negedge clk);
        base = tcyc;
        exp_ev(1, EV_F, 10'h000, 3'b000);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("restart_busy", {31'd0, bus_if.busy}, 32'd1);
        chk("restart_done_low", {31'd0, bus_if.done}, 32'd0);
        wait_done(20);
        chk("restart_halt_cycle", tcyc - base, 32'd4);
        chk("restart_pc", {22'd0, bus_if.pc}, 32'd0);
`ifdef INSTR_SEQ_PERF_EN
        chk("perf_cycles_b", cycle_cnt, 32'd3);
        chk("perf_retired_b", {16'd0, retired_cnt}, 32'd1);
`endif

        // Reset asserted mid-handshake on a long-latency LDR.
        rom[10'h000] = {3'b000, 6'h05}; tk[10'h000] = 1'b0; lat[10'h000] = 50;
        @(negedge clk);
        base = tcyc;
        exp_ev(1, EV_F,  10'h000, 3'b000);
        exp_ev(4, EV_ML, 10'h000, 3'b000);
        exp_ev(5, EV_ML, 10'h000, 3'b000);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_cyc(base + 5);
        chk("pre_reset_mem_req", {31'd0, bus_if.mem_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        chk("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("reset_pc", {22'd0, bus_if.pc}, 32'd0);
        chk("reset_ir", {23'd0, bus_if.ir}, 32'd0);
`ifdef INSTR_SEQ_PERF_EN
        chk("reset_perf_cycles", cycle_cnt, 32'd0);
        chk("reset_perf_retired", {16'd0, retired_cnt}, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {29'd0, bus_if.busy, bus_if.ifetch_en, bus_if.done}, 32'd0);
        chk("queue_empty_end", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
